// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Mode 2'b11 is an alias for no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready handshake into the transmitter's input FIFO.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; read data is always the current head entry.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, runtime divisor, parity and stop-bit count.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_WIDTH-1:0]        clks_per_bit,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    uart_tx_fifo_if.slave               in_if,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [DIV_WIDTH-1:0]   clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [1:0]             par_mode_q, par_mode_d;
    logic                   two_stop_q, two_stop_d;
    logic                   par_bit_q, par_bit_d;
    logic                   second_stop_q, second_stop_d;
    logic                   tx_q, tx_d;

    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;
    logic [DIV_WIDTH-1:0]   div_last;
    logic                   bit_end;
    logic                   load;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_if.in_valid),
        .wr_data (in_if.in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Divisors 0 and 1 both give single-cycle bits.
    assign div_last = (div_q > DIV_WIDTH'(1)) ? div_q - DIV_WIDTH'(1) : '0;
    assign bit_end  = (clk_cnt_q == div_last);

    always_comb begin
        state_d       = state_q;
        clk_cnt_d     = clk_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        div_d         = div_q;
        par_mode_d    = par_mode_q;
        two_stop_d    = two_stop_q;
        par_bit_d     = par_bit_q;
        second_stop_d = second_stop_q;
        tx_d          = tx_q;
        fifo_pop      = 1'b0;
        load          = 1'b0;

        if (state_q != StIdle) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + DIV_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                load = !fifo_empty;
            end
            StStart: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (parity_enabled(par_mode_q)) begin
                            tx_d    = par_bit_q;
                            state_d = StParity;
                        end else begin
                            tx_d          = 1'b1;
                            second_stop_d = 1'b0;
                            state_d       = StStop;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    tx_d          = 1'b1;
                    second_stop_d = 1'b0;
                    state_d       = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (two_stop_q && !second_stop_q) begin
                        second_stop_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Frame start: config is latched here so mid-frame changes wait for the next word.
        if (load) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_head;
            div_d      = clks_per_bit;
            par_mode_d = parity_mode;
            two_stop_d = two_stop;
            par_bit_d  = (^fifo_head) ^ (parity_mode == PAR_ODD);
            clk_cnt_d  = '0;
            tx_d       = 1'b0;
            state_d    = StStart;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            clk_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            div_q         <= '0;
            par_mode_q    <= PAR_NONE;
            two_stop_q    <= 1'b0;
            par_bit_q     <= 1'b0;
            second_stop_q <= 1'b0;
            tx_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            div_q         <= div_d;
            par_mode_q    <= par_mode_d;
            two_stop_q    <= two_stop_d;
            par_bit_q     <= par_bit_d;
            second_stop_q <= second_stop_d;
            tx_q          <= tx_d;
        end
    end

    assign tx             = tx_q;
    assign busy           = (state_q != StIdle) || (fifo_level != '0);
    assign in_if.in_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench: stimulus queues hand-written frame bit strings, monitors check tx.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] clks_per_bit;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        tx8, busy8, tx5, busy5;
    logic [2:0]  lvl8, lvl5;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_if #(.DATA_BITS(8)) bus8 ();
    uart_tx_fifo_if #(.DATA_BITS(5)) bus5 ();

    uart_tx_fifo #(.DATA_BITS(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .clks_per_bit (clks_per_bit),
        .parity_mode  (parity_mode),
        .two_stop     (two_stop),
        .in_if        (bus8),
        .tx           (tx8),
        .busy         (busy8),
        .fifo_level   (lvl8)
    );

    uart_tx_fifo #(.DATA_BITS(5), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut5 (
        .clk          (clk),
        .rst          (rst),
        .clks_per_bit (clks_per_bit),
        .parity_mode  (parity_mode),
        .two_stop     (two_stop),
        .in_if        (bus5),
        .tx           (tx5),
        .busy         (busy5),
        .fifo_level   (lvl5)
    );

    // bits: line levels in transmission order; per: cycles per bit.
    typedef struct {
        string bits;
        int    per;
        bit    b2b;
        bit    abort;
    } frame_t;

    frame_t q0[$];
    frame_t q1[$];

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int m, input string bits, input int per,
                                input bit b2b = 1'b0, input bit abort = 1'b0);
        frame_t f;
        f.bits  = bits;
        f.per   = per;
        f.b2b   = b2b;
        f.abort = abort;
        if (m == 0) q0.push_back(f);
        else        q1.push_back(f);
    endtask

    task automatic push8(input logic [7:0] d);
        bus8.in_data  = d;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
    endtask

    task automatic push5(input logic [4:0] d);
        bus5.in_data  = d;
        bus5.in_valid = 1'b1;
        tick();
        bus5.in_valid = 1'b0;
    endtask

    // Called right after a push edge; returns cycles from tx falling to busy dropping.
    task automatic time_frame(output int n);
        n = 0;
        while (busy8 && n < 1000) begin
            tick();
            n++;
        end
        n = n - 1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((busy8 || busy5) && n < bound) begin
            tick();
            n++;
        end
        check({name, " reaches idle"}, int'(busy8 || busy5), 0);
        tick(2);
    endtask

    function automatic logic mon_tx(input int m);
        return (m == 0) ? tx8 : tx5;
    endfunction

    task automatic run_monitor(input int m);
        int next_start = 0;
        forever begin
            @(negedge clk);
            if (!rst && mon_tx(m) == 1'b0) begin
                frame_t f;
                int     qs;
                int     c0;
                int     errs;
                int     first_bad;
                int     total;
                bit     aborted;
                qs = (m == 0) ? q0.size() : q1.size();
                check($sformatf("mon%0d frame was expected", m), int'(qs > 0), 1);
                if (qs > 0) begin
                    if (m == 0) f = q0.pop_front();
                    else        f = q1.pop_front();
                    c0        = cyc;
                    errs      = 0;
                    first_bad = -1;
                    aborted   = 1'b0;
                    total     = f.bits.len() * f.per;
                    for (int i = 0; i < total; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (mon_tx(m) !== (f.bits.getc(i / f.per) == "1")) begin
                            if (errs == 0) first_bad = i;
                            errs++;
                        end
                    end
                    check($sformatf("mon%0d frame %s aborted", m, f.bits),
                          int'(aborted), int'(f.abort));
                    if (!aborted) begin
                        check($sformatf("mon%0d frame %s per %0d bad cycles (first %0d)",
                                        m, f.bits, f.per, first_bad), errs, 0);
                        if (f.b2b) begin
                            check($sformatf("mon%0d frame %s back-to-back start cycle",
                                            m, f.bits), c0, next_start);
                        end
                    end
                    next_start = c0 + total;
                end
            end
        end
    endtask

    initial begin
        fork
            run_monitor(0);
            run_monitor(1);
        join_none
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, miscompares so far %0d", miscompares);
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] words [5];
        int lv [5];
        int rdy [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        lv    = '{1, 1, 2, 3, 4};
        rdy   = '{1, 1, 1, 1, 0};

        bus8.in_valid = 1'b0;
        bus8.in_data  = '0;
        bus5.in_valid = 1'b0;
        bus5.in_data  = '0;
        clks_per_bit  = 16'd4;
        parity_mode   = PAR_NONE;
        two_stop      = 1'b0;
        rst           = 1'b1;
        tick(3);
        check("reset tx", int'(tx8), 1);
        check("reset busy", int'(busy8), 0);
        check("reset in_ready", int'(bus8.in_ready), 1);
        check("reset fifo_level", int'(lvl8), 0);
        check("reset fifo_level dut5", int'(lvl5), 0);
        rst = 1'b0;
        tick();

        // 8N1, divisor 4, 0xA5
        expect_frame(0, "0101001011", 4);
        push8(8'hA5);
        check("8N1 level after push", int'(lvl8), 1);
        check("8N1 tx still idle after push", int'(tx8), 1);
        check("8N1 busy after push", int'(busy8), 1);
        tick();
        check("8N1 tx low after pop", int'(tx8), 0);
        check("8N1 level after pop", int'(lvl8), 0);
        tick(39);
        check("8N1 busy in last stop cycle", int'(busy8), 1);
        tick();
        check("8N1 busy drops after 40 cycles", int'(busy8), 0);
        check("8N1 tx idle after frame", int'(tx8), 1);
        tick(2);

        // Odd parity, two stop bits
        clks_per_bit = 16'd2;
        parity_mode  = PAR_ODD;
        two_stop     = 1'b1;
        expect_frame(0, "011000000111", 2);
        push8(8'h03);
        time_frame(n);
        check("8O2 0x03 frame cycles", n, 24);
        tick(2);

        // Even parity, one stop bit
        parity_mode = PAR_EVEN;
        two_stop    = 1'b0;
        expect_frame(0, "01110000011", 2);
        push8(8'h07);
        time_frame(n);
        check("8E1 0x07 frame cycles", n, 22);
        tick(2);

        // FIFO fill with in_valid held high
        clks_per_bit = 16'd3;
        parity_mode  = PAR_NONE;
        expect_frame(0, "0100010001", 3);
        expect_frame(0, "0010001001", 3, 1'b1);
        expect_frame(0, "0110011001", 3, 1'b1);
        expect_frame(0, "0001000101", 3, 1'b1);
        expect_frame(0, "0101010101", 3, 1'b1);
        bus8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus8.in_data = words[i];
            tick();
            check($sformatf("fill level after push %0d", i), int'(lvl8), lv[i]);
            check($sformatf("fill in_ready after push %0d", i), int'(bus8.in_ready), rdy[i]);
        end
        bus8.in_data = 8'hEE;
        tick();
        check("fill no push while full", int'(lvl8), 4);
        bus8.in_valid = 1'b0;
        tick(25);
        check("fill level before first pop", int'(lvl8), 4);
        check("fill in_ready before first pop", int'(bus8.in_ready), 0);
        tick();
        check("fill level after first pop", int'(lvl8), 3);
        check("fill in_ready after first pop", int'(bus8.in_ready), 1);
        wait_idle("fill", 300);

        // Divisor 0 and 1 both give single-cycle bits
        clks_per_bit = 16'd0;
        expect_frame(0, "0101001011", 1);
        push8(8'hA5);
        time_frame(n);
        check("divisor 0 frame cycles", n, 10);
        tick(2);
        clks_per_bit = 16'd1;
        expect_frame(0, "0101001011", 1);
        push8(8'hA5);
        time_frame(n);
        check("divisor 1 frame cycles", n, 10);
        tick(2);

        // Divisor changed mid-frame only affects the following frame
        clks_per_bit = 16'd4;
        expect_frame(0, "0100010001", 4);
        expect_frame(0, "0010001001", 8, 1'b1);
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h11;
        tick();
        bus8.in_data  = 8'h22;
        tick();
        bus8.in_valid = 1'b0;
        tick(10);
        clks_per_bit = 16'd8;
        wait_idle("divisor change", 400);

        // Reset during data bit 3 with two words pending
        clks_per_bit = 16'd4;
        expect_frame(0, "0100010001", 4, 1'b0, 1'b1);
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h11;
        tick();
        bus8.in_data  = 8'h22;
        tick();
        bus8.in_data  = 8'h33;
        tick();
        bus8.in_valid = 1'b0;
        check("reset test words pending", int'(lvl8), 2);
        tick(16);
        rst           = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h77;
        tick();
        check("mid-frame reset tx", int'(tx8), 1);
        check("mid-frame reset busy", int'(busy8), 0);
        check("mid-frame reset fifo_level", int'(lvl8), 0);
        check("mid-frame reset in_ready", int'(bus8.in_ready), 1);
        rst           = 1'b0;
        bus8.in_valid = 1'b0;
        tick(100);
        check("no frames after reset", int'(busy8), 0);

        // DATA_BITS=5 instance, 0x1F with even then odd parity
        clks_per_bit = 16'd2;
        parity_mode  = PAR_EVEN;
        two_stop     = 1'b0;
        expect_frame(1, "01111111", 2);
        push5(5'h1F);
        wait_idle("5E1", 100);
        parity_mode = PAR_ODD;
        expect_frame(1, "01111101", 2);
        push5(5'h1F);
        wait_idle("5O1", 100);

        tick(5);
        check("scoreboard 8-bit drained", q0.size(), 0);
        check("scoreboard 5-bit drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter, the successor to our fixed 8N1 transmitter. It has a configurable data width, a small input FIFO with a valid/ready handshake, and a runtime baud divisor, parity mode and stop-bit count. It sits between an on-chip byte producer and the `uo_out` serial pin, and lets a producer queue several characters without polling busy.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5–9, LSB first.
- `DIV_WIDTH`, 16: width of the baud divisor input.
- `FIFO_DEPTH`, 4: input FIFO entries, power of two, ≥2.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `clks_per_bit`  in  DIV_WIDTH  system cycles per UART bit. 0 is treated as 1.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `two_stop`  in  1  0 gives one stop bit, 1 gives two.
- `in_data`  in  DATA_BITS  word to queue.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  FIFO not full.
- `tx`  out  1  serial line, registered.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

## Operation
- Push happens on an edge where `in_valid && in_ready`.
- `in_ready = !full`. It does not depend combinationally on a same-cycle pop.
- Push and pop in the same cycle leave the level unchanged.
- The state machine has five states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If the FIFO is non-empty, on the same edge:
  - pop the head into the shift register;
  - latch `clks_per_bit`, `parity_mode` and `two_stop`;
  - drive `tx`=0 and go to START.
- Configuration changes mid-frame have no effect until the next frame.
- START: hold `tx`=0 for one bit period, then go to DATA with `tx`=data[0].
- DATA: hold each bit for one bit period. After bit DATA_BITS-1:
  - go to PARITY if parity is enabled;
  - otherwise go to STOP.
- PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse. Hold for one bit period, then go to STOP.
- STOP: hold `tx`=1 for one bit period, or two if `two_stop` was latched. At the end of the final stop period:
  - if the FIFO is non-empty, pop the next word and drive `tx`=0 directly (START, back-to-back, no idle cycle);
  - otherwise go to IDLE.
- Bit counter: a `$clog2(DATA_BITS)`-wide counter, compared against DATA_BITS-1. It never wraps past the compare value.
- Clock counter: DIV_WIDTH wide. A bit ends when the counter equals the latched divisor minus 1 (0 when the divisor is 0 or 1). The counter resets to 0 at every bit boundary.
- `busy` = (state != IDLE) || (fifo_level != 0).

## Timing
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `fifo_level`=0, state IDLE, counters 0.
- Reset mid-frame aborts the frame. `tx` is 1 after the reset edge and the FIFO is flushed.
- Reset dominates a same-cycle push.
- Latency from an idle, empty FIFO:
  - word pushed at edge E;
  - `fifo_level`=1 after E;
  - the pop at E+1 drives `tx` low after E+1.
- Frame length in cycles: D × (1 + DATA_BITS + P + S), where D is the latched divisor, P is 1 if parity is enabled, S is 1 or 2.
- Back-to-back frames are separated by no extra cycles.
- `in_ready` falls after the edge that fills the FIFO. It rises after the pop edge that frees a slot.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - the parity-mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`).
- One sub-module, `uart_sync_fifo`:
  - parameters: width and depth;
  - signals: push/pop, full/empty, level;
  - synchronous reset, read data valid from the head register.
- The top level contains the frame state machine, the shift register and the counters.

## Test plan
- **8N1, single word.** Divisor 4, parity none, one stop bit, push 0xA5.
  - `tx` goes low one cycle after the push, for 4 cycles.
  - Data bits follow LSB first: 1,0,1,0,0,1,0,1.
  - Stop bit high for 4 cycles; frame is 40 cycles total; `busy` drops immediately after.
- **Parity and stop bits.** Divisor 2, odd parity, two stop bits, push 0x03: parity bit is 1, frame is 24 cycles. Even parity with 0x07 gives parity bit 1.
- **FIFO fill.** Divisor 3, push 5 words back-to-back with `in_valid` held high.
  - `in_ready` drops once 4 are queued and reasserts at the first pop.
  - All 5 frames come out contiguous with no idle cycles; `fifo_level` sequence is checked.
- **Divisor edge cases.**
  - Divisor 0 and divisor 1 each give 1-cycle bits (10-cycle 8N1 frame).
  - Changing the divisor from 4 to 8 mid-frame: the current frame stays at 4, the next frame uses 8.
- **Reset mid-frame.** Assert `rst` during bit 3 of a queued frame with 2 words pending.
  - After the reset edge: `tx`=1, `busy`=0, `fifo_level`=0.
  - No further frames are sent.
- **DATA_BITS=5 instance.** Push 0x1F with even parity: 5 data bits of 1, then parity bit 1.
